// File: rtl/seq_det_ctrl.sv
// Drives a serial sequence detector one word at a time: clears it, shifts the word out MSB first,
// counts the detector's match cycles and hands the count to a consumer over a valid/ready port.
module seq_det_ctrl #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic [4:0]   in_len,
    output logic         in_ready,
    output logic         det_seq_in,
    output logic         det_rst_n,
    input  logic         detected,
    output logic         out_valid,
    output logic [4:0]   out_count,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StShift,
        StDrain,
        StReport
    } state_e;

    localparam logic [4:0] WLen = 5'(W);

    state_e       state_q, state_d;
    logic [W-1:0] shreg_q, shreg_d;
    logic [4:0]   bitcnt_q, bitcnt_d;
    logic [4:0]   count_q, count_d;
    logic         first_q, first_d;
    logic [4:0]   eff_len;

    assign eff_len = (in_len > WLen) ? WLen : in_len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            count_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            count_q  <= count_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        count_d    = count_q;
        first_d    = first_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        det_seq_in = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d = '0;
                    if (eff_len == 5'd0) begin
                        state_d = StReport;
                    end else begin
                        shreg_d  = in_data;
                        bitcnt_d = eff_len;
                        state_d  = StClr;
                    end
                end
            end
            StClr: begin
                first_d = 1'b1;
                state_d = StShift;
            end
            StShift: begin
                det_seq_in = shreg_q[W-1];
                shreg_d    = {shreg_q[W-2:0], 1'b0};
                bitcnt_d   = bitcnt_q - 5'd1;
                first_d    = 1'b0;
                // The first shift cycle still shows the detector's cleared output, not a real bit.
                if (detected && !first_q) begin
                    count_d = count_q + 5'd1;
                end
                if (bitcnt_q == 5'd1) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (detected) begin
                    count_d = count_q + 5'd1;
                end
                state_d = StReport;
            end
            StReport: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_count = count_q;
    assign busy      = (state_q != StIdle);
    assign det_rst_n = rst_n & (state_q != StClr);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a one-cycle registered detector model and a result
// scoreboard of expected match counts.
module tb_seq_det_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic [4:0]   in_len;
    logic         in_ready;
    logic         det_seq_in;
    logic         det_rst_n;
    logic         detected;
    logic         out_valid;
    logic [4:0]   out_count;
    logic         out_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    seq_det_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_ready   (in_ready),
        .det_seq_in (det_seq_in),
        .det_rst_n  (det_rst_n),
        .detected   (detected),
        .out_valid  (out_valid),
        .out_count  (out_count),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Detector model: seq_in registered one cycle, cleared while det_rst_n is low.
    logic det_q;
    always_ff @(posedge clk) det_q <= det_rst_n ? det_seq_in : 1'b0;
    assign detected = det_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count(input logic [W-1:0] data, input int l);
        int c = 0;
        for (int i = 0; i < l; i++) if (data[W-1-i]) c++;
        return c;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first out_valid cycle.
    task automatic send_word(input logic [W-1:0] data, input logic [4:0] len);
        int l;
        int n;
        logic done;
        logic exp_seq;
        l = (len > 5'(W)) ? W : int'(len);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        in_len   = len;
        exp_q.push_back(model_count(data, l));
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) in_valid = 1'b0;
            exp_seq = 1'b0;
            if (n >= 2 && n <= l + 1) exp_seq = data[W+1-n];
            check($sformatf("det_seq_in d=%h c%0d", data, n), det_seq_in, exp_seq);
            check($sformatf("det_rst_n d=%h c%0d", data, n), det_rst_n,
                  (l > 0 && n == 1) ? 1'b0 : 1'b1);
            if (out_valid) done = 1'b1;
        end
        check($sformatf("out_valid_seen d=%h", data), done, 1);
        check($sformatf("latency d=%h len=%0d", data, len), n, (l == 0) ? 1 : l + 3);
    endtask

    // Holds off the consumer for 'hold' cycles, then accepts and scores the result.
    task automatic receive(input int hold);
        int exp;
        check("queue_nonempty", exp_q.size() != 0, 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        for (int i = 0; i < hold; i++) begin
            check($sformatf("hold_valid %0d", i), out_valid, 1);
            check($sformatf("hold_count %0d", i), out_count, exp);
            check($sformatf("hold_in_ready %0d", i), in_ready, 0);
            check($sformatf("hold_busy %0d", i), busy, 1);
            @(negedge clk);
        end
        check("result_valid", out_valid, 1);
        check("result_count", out_count, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_det_rst_n", det_rst_n, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_count", out_count, 0);
        check("rst_det_seq_in", det_seq_in, 0);
        rst_n = 1'b1;
        #1;
        check("rel_det_rst_n", det_rst_n, 1);
        @(negedge clk);

        send_word(16'hA5F0, 5'd16);
        receive(0);
        send_word(16'hF000, 5'd4);
        receive(2);
        send_word(16'hF000, 5'd20);
        receive(0);
        send_word(16'h1234, 5'd0);
        receive(0);

        // Consumer stalls with a new request pending; it must be taken once back in IDLE.
        send_word(16'h8001, 5'd16);
        in_valid = 1'b1;
        in_data  = 16'hF000;
        in_len   = 5'd4;
        receive(5);
        send_word(16'hF000, 5'd4);
        receive(0);

        // Reset during SHIFT cycle 6 of 16: the word is dropped.
        in_valid = 1'b1;
        in_data  = 16'hA5F0;
        in_len   = 5'd16;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_det_rst_n", det_rst_n, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_in_ready", in_ready, 1);
        check("mid_busy_after", busy, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_out_count", out_count, 0);
        check("mid_det_seq_in", det_seq_in, 0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_result", seen, 0);

        send_word(16'hE000, 5'd3);
        receive(1);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter W, default 16, word width in bits (supported 2..16).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; single clock domain.
REQ-004 in_valid  input  1  word request from requester.
REQ-005 in_data  input  W  word to scan; bits consumed MSB first from bit W-1.
REQ-006 in_len  input  5  number of bits to scan; 0 allowed; values above W treated as W.
REQ-007 in_ready  output  1  controller can accept a word.
REQ-008 det_seq_in  output  1  serial bit to detector seq_in.
REQ-009 det_rst_n  output  1  active-low reset to detector.
REQ-010 detected  input  1  detector match flag, Moore-timed: high in the cycle after the completing bit is sampled.
REQ-011 out_valid  output  1  result available.
REQ-012 out_count  output  5  number of detected cycles counted for the word.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CLR, SHIFT, DRAIN, REPORT.
REQ-016 in_ready SHALL be 1 only in IDLE; a word is accepted on an edge with in_valid=1 in IDLE.
REQ-017 On accept with effective length L>0: capture in_data into shift register, L into bit counter, clear count, go to CLR.
REQ-018 On accept with in_len=0: clear count, go directly to REPORT; no CLR, det_rst_n not pulsed.
REQ-019 CLR SHALL last exactly 1 cycle with det_rst_n=0 and det_seq_in=0, then go to SHIFT.
REQ-020 SHIFT SHALL last exactly L cycles; each cycle det_seq_in = shift register bit W-1, register shifts left by 1 with 0 fill, bit counter decrements.
REQ-021 After the L-th SHIFT cycle, go to DRAIN for exactly 1 cycle with det_seq_in=0, then to REPORT.
REQ-022 count SHALL increment by 1 on each edge where detected=1 in SHIFT cycles 2..L and in DRAIN; detected is ignored in IDLE, CLR, first SHIFT cycle, and REPORT.
REQ-023 count SHALL be 5 bits; maximum value is L ≤ 16, so no wrap occurs.
REQ-024 REPORT: out_valid=1, out_count=count held stable; on edge with out_ready=1 go to IDLE and deassert out_valid.
REQ-025 out_valid and out_count SHALL NOT change while out_valid=1 and out_ready=0; in_valid is ignored outside IDLE.
REQ-026 det_seq_in SHALL be 0 in all states except SHIFT.
REQ-027 det_rst_n SHALL equal 0 when rst_n=0 (combinational) or state=CLR, else 1.
REQ-028 Latency: accept edge at cycle 0 -> out_valid first high in cycle L+3 (CLR 1, SHIFT L, DRAIN 1); for L=0, in cycle 1.

Reset
REQ-029 On an edge with rst_n=0, from any state including mid-SHIFT: state=IDLE, shift register, bit counter, count = 0.
REQ-030 Values after reset: in_ready=1, out_valid=0, out_count=0, det_seq_in=0, busy=0, det_rst_n=1 once rst_n=1.
REQ-031 A word in flight at reset SHALL be discarded with no result reported.

Verification
(Bench detector model: detected = seq_in registered one cycle, cleared by det_rst_n.)
REQ-032 Hold rst_n=0 for 2 edges -> in_ready=1, out_valid=0, busy=0, det_rst_n=0 while rst_n=0.
REQ-033 in_data=16'hA5F0, in_len=16 -> det_seq_in sequence 1010_0101_1111_0000, out_valid in cycle 19, out_count=8.
REQ-034 in_data=16'hF000, in_len=4 -> 4 SHIFT cycles of 1, out_valid in cycle 7, out_count=4; in_len=20 with same data -> treated as 16, out_count=4.
REQ-035 in_len=0 -> out_valid in cycle 1, out_count=0, det_rst_n stays 1, det_seq_in stays 0.
REQ-036 out_ready=0 for 5 cycles in REPORT with in_valid=1 -> out_valid=1, out_count stable, in_ready=0; out_ready=1 -> IDLE next cycle, new word accepted.
REQ-037 rst_n=0 for 1 edge during SHIFT cycle 6 of 16 -> IDLE next cycle, out_valid never asserted for that word, count=0.
